// File: rtl/hicore_ifetch.sv
// HiCore RV32 instruction-fetch front end: owns the fetch PC, keeps up to OUTS
// word fetches in flight and pairs each in-order response with its PC.
module hicore_ifetch #(
   parameter int unsigned    AW       = 32,
   parameter int unsigned    DW       = 32,
   parameter int unsigned    OUTS     = 2,
   parameter logic [AW-1:0]  RESET_PC = 32'h8000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect_vld,
   input  logic [AW-1:0]      redirect_pc,
   output logic               req_vld,
   input  logic               req_rdy,
   output logic [AW-1:0]      req_addr,
   input  logic               rsp_vld,
   output logic               rsp_rdy,
   input  logic [DW-1:0]      rsp_dat,
   input  logic               rsp_err,
   output logic               o_vld,
   input  logic               o_rdy,
   output logic [DW+AW:0]     o_dat,
   output logic               o_cancel
);

   localparam int unsigned CW = $clog2(OUTS + 1);
   localparam int unsigned PW = (OUTS > 1) ? $clog2(OUTS) : 1;
   localparam logic [CW-1:0] OUTS_C  = CW'(OUTS);
   localparam logic [PW-1:0] PTR_MAX = PW'(OUTS - 1);

   logic [AW-1:0] pc;
   logic [CW-1:0] cnt;
   logic [CW-1:0] scnt;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [AW-1:0] pc_fifo [OUTS];

   logic issue;
   logic retire;
   logic busy;

   // Everything is held quiet while reset is asserted, independent of state.
   always_comb begin
      busy     = (cnt != '0);
      req_vld  = rst_n & (cnt < OUTS_C) & ~redirect_vld;
      req_addr = pc;
      o_vld    = rst_n & rsp_vld & busy;
      rsp_rdy  = rst_n & o_rdy & busy;
      o_dat    = {rsp_err, pc_fifo[rd_ptr], rsp_dat};
      o_cancel = rst_n & ((scnt != '0) | redirect_vld);
      issue    = req_vld & req_rdy;
      retire   = rsp_vld & rsp_rdy;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         cnt    <= '0;
         scnt   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (redirect_vld)
            pc <= {redirect_pc[AW-1:2], 2'b00};
         else if (issue)
            pc <= pc + AW'(4);

         if (issue)
            wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PW'(1);
         if (retire)
            rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PW'(1);

         cnt <= cnt + CW'(issue) - CW'(retire);

         // A redirect stales whatever is still in flight after this cycle.
         if (redirect_vld)
            scnt <= cnt - CW'(retire);
         else if (retire && (scnt != '0))
            scnt <= scnt - CW'(1);
      end
   end

   // PC storage needs no reset; pointers alone define which slots are live.
   always_ff @(posedge clk) begin
      if (issue)
         pc_fifo[wr_ptr] <= pc;
   end

endmodule

// File: tb/tb_hicore_ifetch.sv
// Directed-vector bench for hicore_ifetch (OUTS = 2), driving the memory and
// bypass-buffer sides cycle by cycle with hand-computed expectations.
module tb_hicore_ifetch;

   logic        clk;
   logic        rst_n;
   logic        redirect_vld;
   logic [31:0] redirect_pc;
   logic        req_vld;
   logic        req_rdy;
   logic [31:0] req_addr;
   logic        rsp_vld;
   logic        rsp_rdy;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        o_vld;
   logic        o_rdy;
   logic [64:0] o_dat;
   logic        o_cancel;

   int checks_total;
   int checks_passed;

   hicore_ifetch #(
      .AW(32), .DW(32), .OUTS(2), .RESET_PC(32'h8000_0000)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .o_cancel(o_cancel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic applyStimulus(input logic rn, input logic rrdy,
                                input logic rv, input logic [31:0] dat,
                                input logic err, input logic ordy,
                                input logic redir, input logic [31:0] rpc);
      @(negedge clk);
      rst_n        = rn;
      req_rdy      = rrdy;
      rsp_vld      = rv;
      rsp_dat      = dat;
      rsp_err      = err;
      o_rdy        = ordy;
      redirect_vld = redir;
      redirect_pc  = rpc;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [95:0] actual,
                              input logic [95:0] expected);
      checks_total++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      else
         checks_passed++;
   endtask

   function automatic logic [64:0] mkDat(input logic err, input logic [31:0] pcv,
                                         input logic [31:0] ins);
      return {err, pcv, ins};
   endfunction

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      rst_n = 1'b0; req_rdy = 1'b0; rsp_vld = 1'b0; rsp_dat = '0; rsp_err = 1'b0;
      o_rdy = 1'b0; redirect_vld = 1'b0; redirect_pc = '0;

      // Reset held: outputs quiet even with redirect and response asserted.
      applyStimulus(0, 1, 1, 32'h0, 0, 1, 1, 32'h0000_1000);
      applyStimulus(0, 1, 1, 32'h0, 0, 1, 1, 32'h0000_1000);
      checkOutput("rst_req_vld",  96'(req_vld),  96'(0));
      checkOutput("rst_o_vld",    96'(o_vld),    96'(0));
      checkOutput("rst_rsp_rdy",  96'(rsp_rdy),  96'(0));
      checkOutput("rst_o_cancel", 96'(o_cancel), 96'(0));

      // Release: first fetch from RESET_PC.
      applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, 32'h0);
      checkOutput("rel_req_vld",  96'(req_vld),  96'(1));
      checkOutput("rel_req_addr", 96'(req_addr), 96'(32'h8000_0000));

      // Single-cycle memory: response for 0x8000_0000 while issuing 0x8000_0004.
      applyStimulus(1, 1, 1, 32'h0000_0011, 0, 1, 0, 32'h0);
      checkOutput("seq_addr1",    96'(req_addr), 96'(32'h8000_0004));
      checkOutput("seq_o_vld",    96'(o_vld),    96'(1));
      checkOutput("seq_rsp_rdy",  96'(rsp_rdy),  96'(1));
      checkOutput("seq_dat0",     96'(o_dat),    96'(mkDat(0, 32'h8000_0000, 32'h11)));
      checkOutput("seq_cancel0",  96'(o_cancel), 96'(0));

      applyStimulus(1, 0, 1, 32'h0000_0022, 0, 1, 0, 32'h0);
      checkOutput("seq_dat1",     96'(o_dat),    96'(mkDat(0, 32'h8000_0004, 32'h22)));
      checkOutput("seq_addr2",    96'(req_addr), 96'(32'h8000_0008));

      // Fill to OUTS with no responses.
      applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, 32'h0);
      checkOutput("fill_addr0",   96'(req_addr), 96'(32'h8000_0008));
      applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, 32'h0);
      checkOutput("fill_vld1",    96'(req_vld),  96'(1));
      checkOutput("fill_addr1",   96'(req_addr), 96'(32'h8000_000C));
      applyStimulus(1, 1, 1, 32'h0000_0033, 0, 0, 0, 32'h0);
      checkOutput("full_req_vld", 96'(req_vld),  96'(0));
      checkOutput("bp_rsp_rdy",   96'(rsp_rdy),  96'(0));
      checkOutput("bp_o_vld",     96'(o_vld),    96'(1));
      applyStimulus(1, 1, 1, 32'h0000_0033, 0, 1, 0, 32'h0);
      checkOutput("bp_release",   96'(rsp_rdy),  96'(1));
      checkOutput("bp_dat",       96'(o_dat),    96'(mkDat(0, 32'h8000_0008, 32'h33)));
      checkOutput("full_same_cy", 96'(req_vld),  96'(0));
      applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, 32'h0);
      checkOutput("refill_vld",   96'(req_vld),  96'(1));
      checkOutput("refill_addr",  96'(req_addr), 96'(32'h8000_0010));

      // Redirect with two in flight (0x..0C, 0x..10).
      applyStimulus(1, 1, 0, 32'h0, 0, 1, 1, 32'h0000_1003);
      checkOutput("redir_req_vld", 96'(req_vld),  96'(0));
      checkOutput("redir_cancel",  96'(o_cancel), 96'(1));
      applyStimulus(1, 1, 1, 32'h0000_0044, 0, 1, 0, 32'h0);
      checkOutput("stale0_cancel", 96'(o_cancel), 96'(1));
      checkOutput("stale0_dat",    96'(o_dat),    96'(mkDat(0, 32'h8000_000C, 32'h44)));
      checkOutput("redir_addr",    96'(req_addr), 96'(32'h0000_1000));
      applyStimulus(1, 1, 1, 32'h0000_0045, 0, 1, 0, 32'h0);
      checkOutput("stale1_cancel", 96'(o_cancel), 96'(1));
      checkOutput("stale1_dat",    96'(o_dat),    96'(mkDat(0, 32'h8000_0010, 32'h45)));
      checkOutput("new_req_vld",   96'(req_vld),  96'(1));
      applyStimulus(1, 0, 1, 32'h0000_0046, 0, 1, 0, 32'h0);
      checkOutput("new_cancel",    96'(o_cancel), 96'(0));
      checkOutput("new_dat",       96'(o_dat),    96'(mkDat(0, 32'h0000_1000, 32'h46)));

      // Redirect coinciding with a retire at cnt = 2.
      applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, 32'h0);
      checkOutput("r2_addr0",      96'(req_addr), 96'(32'h0000_1004));
      applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, 32'h0);
      checkOutput("r2_addr1",      96'(req_addr), 96'(32'h0000_1008));
      applyStimulus(1, 1, 1, 32'h0000_0050, 0, 1, 1, 32'h0000_2000);
      checkOutput("r2_ret_cancel", 96'(o_cancel), 96'(1));
      checkOutput("r2_ret_rdy",    96'(rsp_rdy),  96'(1));
      checkOutput("r2_ret_dat",    96'(o_dat),    96'(mkDat(0, 32'h0000_1004, 32'h50)));
      applyStimulus(1, 0, 1, 32'h0000_0051, 0, 1, 0, 32'h0);
      checkOutput("r2_tail_cancel", 96'(o_cancel), 96'(1));
      checkOutput("r2_tail_dat",    96'(o_dat),    96'(mkDat(0, 32'h0000_1008, 32'h51)));
      checkOutput("r2_new_addr",    96'(req_addr), 96'(32'h0000_2000));
      applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, 32'h0);
      applyStimulus(1, 0, 1, 32'h0000_0052, 0, 1, 0, 32'h0);
      checkOutput("r2_new_cancel",  96'(o_cancel), 96'(0));
      checkOutput("r2_new_dat",     96'(o_dat),    96'(mkDat(0, 32'h0000_2000, 32'h52)));

      // PC wrap and error pass-through.
      applyStimulus(1, 0, 0, 32'h0, 0, 1, 1, 32'hFFFF_FFFE);
      applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, 32'h0);
      checkOutput("wrap_addr0",    96'(req_addr), 96'(32'hFFFF_FFFC));
      applyStimulus(1, 1, 1, 32'h0000_0055, 1, 1, 0, 32'h0);
      checkOutput("wrap_addr1",    96'(req_addr), 96'(32'h0000_0000));
      checkOutput("err_dat",       96'(o_dat),    96'(mkDat(1, 32'hFFFF_FFFC, 32'h55)));
      applyStimulus(1, 0, 1, 32'h0000_0066, 0, 1, 0, 32'h0);
      checkOutput("err_cont_vld",  96'(req_vld),  96'(1));
      checkOutput("err_cont_addr", 96'(req_addr), 96'(32'h0000_0004));
      checkOutput("post_err_dat",  96'(o_dat),    96'(mkDat(0, 32'h0000_0000, 32'h66)));

      // Spurious response with nothing in flight is blocked and changes nothing.
      applyStimulus(1, 0, 1, 32'h0000_0077, 0, 1, 0, 32'h0);
      checkOutput("spur_o_vld",    96'(o_vld),    96'(0));
      checkOutput("spur_rsp_rdy",  96'(rsp_rdy),  96'(0));
      applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, 32'h0);
      checkOutput("spur_addr",     96'(req_addr), 96'(32'h0000_0004));

      // Reset mid-operation with one request in flight.
      applyStimulus(0, 1, 0, 32'h0, 0, 1, 0, 32'h0);
      checkOutput("mid_rst_vld",   96'(req_vld),  96'(0));
      applyStimulus(1, 0, 1, 32'h0000_0088, 0, 1, 0, 32'h0);
      checkOutput("mid_rst_o_vld", 96'(o_vld),    96'(0));
      checkOutput("mid_rst_addr",  96'(req_addr), 96'(32'h8000_0000));
      checkOutput("mid_rst_req",   96'(req_vld),  96'(1));

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
